// File: rtl/l2_arbiter_if.sv
// I-side, D-side and L2-side request/response bundle for l2_arbiter.
// slave = arbiter view, master = environment view.
interface l2_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  i_req_valid;
  logic                  i_req_ready;
  logic [ADDR_WIDTH-1:0] i_req_addr;
  logic                  i_resp_valid;
  logic [DATA_WIDTH-1:0] i_resp_rdata;

  logic                  d_req_valid;
  logic                  d_req_ready;
  logic                  d_req_wr;
  logic [ADDR_WIDTH-1:0] d_req_addr;
  logic [DATA_WIDTH-1:0] d_req_wdata;
  logic                  d_resp_valid;
  logic [DATA_WIDTH-1:0] d_resp_rdata;

  logic                  l2_req_valid;
  logic                  l2_req_wr;
  logic [ADDR_WIDTH-1:0] l2_req_addr;
  logic [DATA_WIDTH-1:0] l2_req_wdata;
  logic                  l2_resp_valid;
  logic [DATA_WIDTH-1:0] l2_resp_rdata;

  modport slave (
    input  i_req_valid, i_req_addr,
    output i_req_ready, i_resp_valid, i_resp_rdata,
    input  d_req_valid, d_req_wr, d_req_addr, d_req_wdata,
    output d_req_ready, d_resp_valid, d_resp_rdata,
    output l2_req_valid, l2_req_wr, l2_req_addr, l2_req_wdata,
    input  l2_resp_valid, l2_resp_rdata
  );

  modport master (
    output i_req_valid, i_req_addr,
    input  i_req_ready, i_resp_valid, i_resp_rdata,
    output d_req_valid, d_req_wr, d_req_addr, d_req_wdata,
    input  d_req_ready, d_resp_valid, d_resp_rdata,
    input  l2_req_valid, l2_req_wr, l2_req_addr, l2_req_wdata,
    output l2_resp_valid, l2_resp_rdata
  );
endinterface

// File: rtl/l2_arbiter.sv
// I/D to L2 request arbiter with in-order response routing via an ID FIFO.
// Define L2_ARB_DSIDE_PRIO_EN for fixed D-side priority instead of round-robin.
module l2_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_OUTST  = 8
) (
  input  logic         clk,
  input  logic         rst,
  l2_arbiter_if.slave  bus,
  output logic         err_spurious
);
  localparam int PW = $clog2(MAX_OUTST);
  localparam int CW = PW + 1;

  logic [MAX_OUTST-1:0] id_q;
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [CW-1:0]        count;
  logic                 last_d;

  logic free;
  logic gnt_i;
  logic gnt_d;
  logic push;
  logic pop;
  logic pop_id;
  logic spurious;

  always_comb begin
    free  = !rst && (count < CW'(MAX_OUTST));
    gnt_i = 1'b0;
    gnt_d = 1'b0;
    if (free) begin
`ifdef L2_ARB_DSIDE_PRIO_EN
      gnt_d = bus.d_req_valid;
      gnt_i = bus.i_req_valid && !bus.d_req_valid;
`else
      if (bus.i_req_valid && bus.d_req_valid) begin
        gnt_i = last_d;
        gnt_d = !last_d;
      end else begin
        gnt_i = bus.i_req_valid;
        gnt_d = bus.d_req_valid;
      end
`endif
    end
  end

  assign bus.i_req_ready = gnt_i;
  assign bus.d_req_ready = gnt_d;

  assign push     = gnt_i || gnt_d;
  assign pop      = bus.l2_resp_valid && (count != '0);
  assign spurious = bus.l2_resp_valid && (count == '0);
  assign pop_id   = id_q[rd_ptr];

  // ID storage needs no reset: only entries below count are ever read
  always_ff @(posedge clk) begin
    if (push) id_q[wr_ptr] <= gnt_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count             <= '0;
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      last_d            <= 1'b1;
      bus.l2_req_valid  <= 1'b0;
      bus.l2_req_wr     <= 1'b0;
      bus.l2_req_addr   <= '0;
      bus.l2_req_wdata  <= '0;
      bus.i_resp_valid  <= 1'b0;
      bus.i_resp_rdata  <= '0;
      bus.d_resp_valid  <= 1'b0;
      bus.d_resp_rdata  <= '0;
      err_spurious      <= 1'b0;
    end else begin
      bus.l2_req_valid <= push;
      if (push) begin
        wr_ptr           <= wr_ptr + 1'b1;
        last_d           <= gnt_d;
        bus.l2_req_wr    <= gnt_d && bus.d_req_wr;
        bus.l2_req_addr  <= gnt_d ? bus.d_req_addr : bus.i_req_addr;
        bus.l2_req_wdata <= gnt_d ? bus.d_req_wdata : '0;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      bus.i_resp_valid <= pop && !pop_id;
      bus.d_resp_valid <= pop && pop_id;
      if (pop && !pop_id) bus.i_resp_rdata <= bus.l2_resp_rdata;
      if (pop && pop_id)  bus.d_resp_rdata <= bus.l2_resp_rdata;
      if (spurious) err_spurious <= 1'b1;
    end
  end
endmodule

// File: tb/tb_l2_arbiter.sv
// Bench for l2_arbiter: queue-based reference model, latency-programmable
// L2 responder, and directed scenarios with literal expectations.
module tb_l2_arbiter;
  localparam int MAXO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic err_spurious;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   started = 0;

  always #5 clk = ~clk;

  l2_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  l2_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .MAX_OUTST(MAXO)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .err_spurious(err_spurious)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL %s timed out (cycle %0d)", nm, cyc);
  endtask

  // reference model: outstanding IDs as a plain queue (0 = I, 1 = D)
  bit          q[$];
  bit          m_last_d = 1;
  bit          m_l2_v = 0, m_l2_wr = 0;
  logic [31:0] m_l2_addr = 0, m_l2_wdata = 0;
  bit          m_iv = 0, m_dv = 0, m_err = 0;
  logic [31:0] m_ird = 0, m_drd = 0;
  bit          exp_gi = 0, exp_gd = 0;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      q.delete();
      m_last_d = 1; m_l2_v = 0; m_l2_wr = 0; m_l2_addr = 0; m_l2_wdata = 0;
      m_iv = 0; m_dv = 0; m_ird = 0; m_drd = 0; m_err = 0;
    end else begin
      m_iv = 0; m_dv = 0;
      if (bus.l2_resp_valid) begin
        if (q.size() > 0) begin
          if (q.pop_front()) begin m_dv = 1; m_drd = bus.l2_resp_rdata; end
          else begin m_iv = 1; m_ird = bus.l2_resp_rdata; end
        end else m_err = 1;
      end
      if (exp_gi) begin
        q.push_back(0); m_last_d = 0;
        m_l2_v = 1; m_l2_wr = 0; m_l2_addr = bus.i_req_addr; m_l2_wdata = 0;
      end else if (exp_gd) begin
        q.push_back(1); m_last_d = 1;
        m_l2_v = 1; m_l2_wr = bus.d_req_wr;
        m_l2_addr = bus.d_req_addr; m_l2_wdata = bus.d_req_wdata;
      end else m_l2_v = 0;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      exp_gi = 0; exp_gd = 0;
      if (!rst && q.size() < MAXO) begin
`ifdef L2_ARB_DSIDE_PRIO_EN
        if (bus.d_req_valid) exp_gd = 1;
        else exp_gi = bus.i_req_valid;
`else
        if (bus.i_req_valid && bus.d_req_valid) begin
          exp_gi = m_last_d; exp_gd = !m_last_d;
        end else begin
          exp_gi = bus.i_req_valid; exp_gd = bus.d_req_valid;
        end
`endif
      end
      chk("i_req_ready", bus.i_req_ready, exp_gi);
      chk("d_req_ready", bus.d_req_ready, exp_gd);
      chk("l2_req_valid", bus.l2_req_valid, m_l2_v);
      if (m_l2_v) begin
        chk("l2_req_addr", bus.l2_req_addr, m_l2_addr);
        chk("l2_req_wr", bus.l2_req_wr, m_l2_wr);
        chk("l2_req_wdata", bus.l2_req_wdata, m_l2_wdata);
      end
      chk("i_resp_valid", bus.i_resp_valid, m_iv);
      chk("d_resp_valid", bus.d_resp_valid, m_dv);
      chk("i_resp_rdata", bus.i_resp_rdata, m_ird);
      chk("d_resp_rdata", bus.d_resp_rdata, m_drd);
      chk("err_spurious", err_spurious, m_err);
    end
  end

  // L2 responder: fixed latency, in order, plus a spurious-pulse injector
  typedef struct { int due; logic [31:0] data; } pend_t;
  pend_t pend[$];
  int    lat = 5;
  bit    inject = 0;

  function automatic logic [31:0] l2_data(input logic [31:0] a, input bit wr,
                                          input logic [31:0] wd);
    if (wr) return ~wd;
    if (a == 32'h100) return 32'hDEADBEEF;
    return a * 32'h01010101 + 32'd7;
  endfunction

  always @(negedge clk) begin
    if (bus.l2_req_valid === 1'b1)
      pend.push_back('{cyc + lat,
        l2_data(bus.l2_req_addr, bus.l2_req_wr, bus.l2_req_wdata)});
  end

  always @(posedge clk) begin
    pend_t p;
    #1;
    if (inject) begin
      bus.l2_resp_valid = 1; bus.l2_resp_rdata = 32'h5A5A5A5A; inject = 0;
    end else if (pend.size() > 0 && pend[0].due <= cyc) begin
      p = pend.pop_front();
      bus.l2_resp_valid = 1; bus.l2_resp_rdata = p.data;
    end else begin
      bus.l2_resp_valid = 0; bus.l2_resp_rdata = 32'h0;
    end
  end

  // side log of DUT responses (0 = I, 1 = D)
  bit side_log[$];
  always @(negedge clk) begin
    if (bus.i_resp_valid === 1'b1) side_log.push_back(0);
    if (bus.d_resp_valid === 1'b1) side_log.push_back(1);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send_i(input logic [31:0] a);
    int n = 0;
    bus.i_req_valid = 1; bus.i_req_addr = a;
    do begin @(negedge clk); n++; end while (!bus.i_req_ready && n < 100);
    if (!bus.i_req_ready) timeout("send_i");
    tick();
    bus.i_req_valid = 0;
  endtask

  task automatic send_d(input bit wr, input logic [31:0] a,
                        input logic [31:0] wd);
    int n = 0;
    bus.d_req_valid = 1; bus.d_req_wr = wr;
    bus.d_req_addr = a; bus.d_req_wdata = wd;
    do begin @(negedge clk); n++; end while (!bus.d_req_ready && n < 100);
    if (!bus.d_req_ready) timeout("send_d");
    tick();
    bus.d_req_valid = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((q.size() != 0 || pend.size() != 0) && n < 300) begin
      tick(); n++;
    end
    if (n >= 300) timeout("idle");
    tick(); tick();
  endtask

  task automatic do_reset();
    rst = 1; tick(); rst = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int k, n;
    logic [47:0] gseq, gexp;
    logic [2:0]  olog;
    bus.i_req_valid = 0; bus.i_req_addr = 0;
    bus.d_req_valid = 0; bus.d_req_wr = 0;
    bus.d_req_addr = 0; bus.d_req_wdata = 0;
    bus.l2_resp_valid = 0; bus.l2_resp_rdata = 0;
    @(posedge clk);
    started = 1;
    #2;
    bus.i_req_valid = 1; bus.d_req_valid = 1;
    @(negedge clk);
    chk("rst_i_ready", bus.i_req_ready, 0);
    chk("rst_d_ready", bus.d_req_ready, 0);
    chk("rst_l2_valid", bus.l2_req_valid, 0);
    chk("rst_l2_addr", bus.l2_req_addr, 0);
    chk("rst_err", err_spurious, 0);
    tick();
    bus.i_req_valid = 0; bus.d_req_valid = 0;
    rst = 0;
    tick();

    // single I read
    send_i(32'h100);
    @(negedge clk);
    chk("rd_l2_valid", bus.l2_req_valid, 1);
    chk("rd_l2_addr", bus.l2_req_addr, 32'h100);
    chk("rd_l2_wr", bus.l2_req_wr, 0);
    k = 0;
    do begin @(negedge clk); k++; end while (!bus.i_resp_valid && k < 30);
    chk("rd_latency", k, 6);
    chk("rd_rdata", bus.i_resp_rdata, 32'hDEADBEEF);
    chk("rd_d_valid", bus.d_resp_valid, 0);
    wait_idle();

    // tie after reset
    do_reset();
    lat = 3;
    bus.i_req_valid = 1; bus.i_req_addr = 32'h200;
    bus.d_req_valid = 1; bus.d_req_wr = 0; bus.d_req_addr = 32'h300;
    gseq = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      gseq = {gseq[39:0], bus.i_req_ready ? 8'h49 : bus.d_req_ready ? 8'h44 : 8'h2D};
      tick();
    end
    bus.i_req_valid = 0; bus.d_req_valid = 0;
`ifdef L2_ARB_DSIDE_PRIO_EN
    gexp = "DDDDDD";
`else
    gexp = "IDIDID";
`endif
    chk("tie_seq", gseq, gexp);
    wait_idle();

    // full: 8 outstanding, then one transfer per pop
    lat = 20;
    bus.d_req_valid = 1; bus.d_req_wr = 0; bus.d_req_addr = 32'h400;
    n = 0; k = 0;
    while (k < 60) begin
      @(negedge clk);
      if (bus.l2_resp_valid) break;
      if (bus.d_req_ready) n++;
      tick(); k++;
    end
    if (k >= 60) timeout("full_first_resp");
    chk("full_count", n, 8);
    tick();
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.d_req_ready) n++;
      tick();
    end
    chk("full_refill", n, 8);
    bus.d_req_valid = 0;
    wait_idle();
    lat = 5;

    // ordering, then wrap with 20 mixed requests
    side_log.delete();
    send_i(32'h10);
    send_d(1, 32'h20, 32'h55);
    send_i(32'h30);
    wait_idle();
    olog = '1;
    if (side_log.size() == 3) olog = {side_log[0], side_log[1], side_log[2]};
    chk("order_cnt", side_log.size(), 3);
    chk("order_side", olog, 3'b010);
    chk("order_d_rdata", bus.d_resp_rdata, 32'hFFFFFFAA);
    chk("order_i_rdata", bus.i_resp_rdata, 32'h30303037);
    side_log.delete();
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 1) send_d(i % 4 == 1, 32'h1000 + i * 4, 32'hA0 + i);
      else send_i(32'h2000 + i * 4);
    end
    wait_idle();
    chk("wrap_resps", side_log.size(), 20);

    // spurious response and reset clearing
    inject = 1;
    tick(); tick(); tick();
    @(negedge clk);
    chk("spur_set", err_spurious, 1);
    tick();
    rst = 1;
    tick();
    @(negedge clk);
    chk("spur_clear", err_spurious, 0);
    rst = 0;
    tick();

    // reset with requests in flight: late responses are spurious
    send_i(32'h500);
    send_d(0, 32'h600, 0);
    do_reset();
    wait_idle();
    @(negedge clk);
    chk("midrst_err", err_spurious, 1);
    do_reset();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/l2_arbiter.md
L2_ARBITER -- requirements
Module: l2_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, request address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, data word width.
REQ-003 SHALL have parameter MAX_OUTST, default 8, power of two ≥ 2, max in-flight L2 requests.
REQ-004 SHALL have ports: clk in 1, sole clock (rising edge); rst in 1, synchronous active-high reset.
REQ-005 SHALL have I-side ports: i_req_valid in 1; i_req_ready out 1; i_req_addr in ADDR_WIDTH; i_resp_valid out 1; i_resp_rdata out DATA_WIDTH (read-only requester).
REQ-006 SHALL have D-side ports: d_req_valid in 1; d_req_ready out 1; d_req_wr in 1; d_req_addr in ADDR_WIDTH; d_req_wdata in DATA_WIDTH; d_resp_valid out 1; d_resp_rdata out DATA_WIDTH.
REQ-007 SHALL have L2-side ports: l2_req_valid out 1; l2_req_wr out 1; l2_req_addr out ADDR_WIDTH; l2_req_wdata out DATA_WIDTH; l2_resp_valid in 1; l2_resp_rdata in DATA_WIDTH (L2 accepts every request, returns in order).
REQ-008 SHALL have err_spurious out 1, sticky flag for a response with no outstanding request.

Function
REQ-009 SHALL hold an ID FIFO (1 bit/entry: 0=I, 1=D) of MAX_OUTST entries, registered occupancy count 0..MAX_OUTST.
REQ-010 SHALL drive i_req_ready and d_req_ready from the arbitration result only; grant possible only while count < MAX_OUTST (no same-cycle pop bypass).
REQ-011 SHALL grant at most one requester per cycle; a transfer occurs when valid && ready.
REQ-012 SHALL arbitrate round-robin when both valid: grant side opposite to last_grant; single valid requester granted alone.
REQ-013 SHALL update last_grant only on a transfer.
REQ-014 SHALL on transfer in cycle N register l2_req_valid=1, addr, wr (I-side: wr=0, wdata=0), wdata for cycle N+1; l2_req_valid=0 in cycles without transfer.
REQ-015 SHALL push granted ID into FIFO in cycle N.
REQ-016 SHALL on l2_resp_valid in cycle M with count>0 pop FIFO head and register resp_valid/rdata on the matching side in cycle M+1; other side resp_valid=0.
REQ-017 SHALL return D-side write responses like reads (d_resp_valid pulse; rdata = L2 data).
REQ-018 SHALL handle simultaneous push and pop: count unchanged, both pointers advance.
REQ-019 SHALL wrap FIFO pointers modulo MAX_OUTST.
REQ-020 SHALL on l2_resp_valid with count=0: drop data, no resp_valid, set err_spurious=1 until reset, count stays 0.
REQ-021 SHALL keep resp_rdata outputs holding last value when resp_valid=0.

Reset
REQ-022 SHALL on rst=1 at clk edge clear: count, pointers, l2_req_valid, l2_req_wr, l2_req_addr, l2_req_wdata, i/d_resp_valid, i/d_resp_rdata, err_spurious to 0; last_grant=D (I wins first tie).
REQ-023 SHALL drive i_req_ready=d_req_ready=0 while rst=1.
REQ-024 SHALL discard all in-flight IDs on reset mid-operation; L2 responses arriving after reset release set err_spurious.

Configuration
REQ-025 SHALL, with macro L2_ARB_DSIDE_PRIO_EN defined, replace round-robin by fixed priority: D granted whenever d_req_valid and slot free; I granted only when d_req_valid=0.
REQ-026 SHALL, without L2_ARB_DSIDE_PRIO_EN, use round-robin per REQ-012; all other behaviour identical.

Verification
REQ-027 SHALL test single I read: i_req addr 0x100, L2 model latency 5 returns 0xDEADBEEF -> l2_req_valid at N+1, i_resp_valid with 0xDEADBEEF at resp cycle+1, d_resp_valid stays 0.
REQ-028 SHALL test tie: both valid continuously for 6 cycles after reset -> grants I,D,I,D,I,D (macro off); D×6 (macro on).
REQ-029 SHALL test full: MAX_OUTST=8, L2 latency 20, d_req_valid held -> exactly 8 transfers, ready=0 until first response, then one transfer per pop.
REQ-030 SHALL test ordering: I 0x10, D write 0x20 data 0x55, I 0x30 back-to-back -> responses routed I,D,I in order, pointer wrap exercised over 20 requests.
REQ-031 SHALL test spurious: l2_resp_valid pulse with count=0 -> err_spurious=1, no resp_valid; rst=1 clears it to 0.
